// File: rtl/age_nloop_pkg.sv
// Shared types for the nested-loop address generator:
// FSM encoding, latched configuration and per-beat sidebands.
package age_nloop_pkg;

  localparam int unsigned AGE_N_DIMS     = 3;
  localparam int unsigned NBIT_FLAT_ADDR = 20;

  typedef enum logic [1:0] {
    AGE_IDLE  = 2'd0,
    AGE_RUN   = 2'd1,
    AGE_DRAIN = 2'd2,
    AGE_DONE  = 2'd3
  } age_state_e;

  typedef struct packed {
    logic [3:0] log2_block;
    logic       lns;
    logic       acc_mode;
  } age_cfg_t;

  typedef struct packed {
    logic valid;
    logic last;
    logic acc_last;
    logic lns;
  } age_beat_t;

endpackage

// File: rtl/age_nloop_loop_ctr.sv
// N-deep odometer: dim 0 fastest, each dim wraps after bound-1.
// last_o marks the final tuple; inner_wrap_o marks dim 0 at bound-1.
module age_loop_ctr
  import age_nloop_pkg::*;
#(
  parameter int unsigned N_DIMS  = AGE_N_DIMS,
  parameter int unsigned NBIT_IV = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [N_DIMS*NBIT_IV-1:0] bounds_i,
  output logic [N_DIMS*NBIT_IV-1:0] iv_o,
  output logic                      inner_wrap_o,
  output logic                      last_o
);

  logic [N_DIMS*NBIT_IV-1:0] iv_q, iv_d;
  logic [N_DIMS:0]           carry;
  logic [N_DIMS-1:0]         at_max;

  always_comb begin
    iv_d     = iv_q;
    carry    = '0;
    at_max   = '0;
    carry[0] = 1'b1;
    for (int k = 0; k < N_DIMS; k++) begin
      at_max[k] = iv_q[k*NBIT_IV +: NBIT_IV] ==
                  bounds_i[k*NBIT_IV +: NBIT_IV] - NBIT_IV'(1);
      carry[k+1] = carry[k] & at_max[k];
      if (carry[k])
        iv_d[k*NBIT_IV +: NBIT_IV] = at_max[k] ? '0 :
          iv_q[k*NBIT_IV +: NBIT_IV] + NBIT_IV'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) iv_q <= '0;
    else if (en_i)      iv_q <= iv_d;
  end

  assign iv_o         = iv_q;
  assign inner_wrap_o = at_max[0];
  assign last_o       = carry[N_DIMS];

endmodule

// File: rtl/age_nloop.sv
// Three-stage nested-loop address generator with block-cyclic
// bank split, valid/ready output, abort and done pulse.
module age_nloop
  import age_nloop_pkg::*;
#(
  parameter int unsigned N_DIMS      = AGE_N_DIMS,
  parameter int unsigned NBIT_IV     = 8,
  parameter int unsigned NBIT_STRIDE = 16,
  parameter int unsigned NBIT_FLAT   = NBIT_FLAT_ADDR,
  parameter int unsigned N_BANKS     = 8,
  parameter int unsigned NBIT_ADDR   = 16,
  parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
  parameter int unsigned NBIT_LNB    = $clog2(LOG_N_BANKS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [N_DIMS*NBIT_IV-1:0]     bounds_i,
  input  logic [N_DIMS*NBIT_STRIDE-1:0] strides_i,
  input  logic [NBIT_FLAT-1:0]          iv_const_i,
  input  logic [NBIT_LNB-1:0]           log2_n_banks_i,
  input  logic [LOG_N_BANKS-1:0]        start_bank_i,
  input  logic [3:0]                    log2_block_i,
  input  logic                          lns_i,
  input  logic                          acc_mode_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [NBIT_ADDR-1:0]          addr_o,
  output logic [N_BANKS-1:0]            bank_o,
  output logic [LOG_N_BANKS-1:0]        bank_idx_o,
  output logic                          lns_o,
  output logic                          last_o,
  output logic                          acc_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam logic [1:0] S_IDLE  = AGE_IDLE;
  localparam logic [1:0] S_RUN   = AGE_RUN;
  localparam logic [1:0] S_DRAIN = AGE_DRAIN;
  localparam logic [1:0] S_DONE  = AGE_DONE;

  logic [1:0] state_q, state_d;

  age_cfg_t                      cfg_q;
  logic [N_DIMS*NBIT_IV-1:0]     bounds_q;
  logic [N_DIMS*NBIT_STRIDE-1:0] strides_q;
  logic [NBIT_FLAT-1:0]          const_q;
  logic [NBIT_LNB-1:0]           nbanks_q;
  logic [LOG_N_BANKS-1:0]        sbank_q;

  logic [N_DIMS*NBIT_IV-1:0] iv;
  logic inner_wrap, ctr_last;
  logic en, issue, launch, any_zero;

  age_beat_t            s1_q, s2_q;
  logic [NBIT_FLAT-1:0] sum_c, s1_sum_q, s2_f_q;

  logic [4:0]             sh_hi;
  logic [LOG_N_BANKS-1:0] bmask, bidx_c;
  logic [NBIT_ADDR-1:0]   addr_c;
  logic [N_BANKS-1:0]     bank_d;

  // A held output beat freezes the whole pipe, counters included.
  assign en     = !(valid_o && !ready_i);
  assign issue  = (state_q == S_RUN) && en;
  assign launch = (state_q == S_IDLE) && start_i && !abort_i;

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < N_DIMS; k++)
      if (bounds_i[k*NBIT_IV +: NBIT_IV] == '0) any_zero = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = any_zero ? S_DONE : S_RUN;
      S_RUN:   if (issue && ctr_last) state_d = S_DRAIN;
      S_DRAIN: if (!s1_q.valid && !s2_q.valid && !valid_o)
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q     <= '0;
      bounds_q  <= '0;
      strides_q <= '0;
      const_q   <= '0;
      nbanks_q  <= '0;
      sbank_q   <= '0;
    end else if (launch) begin
      cfg_q     <= '{log2_block: log2_block_i,
                     lns: lns_i, acc_mode: acc_mode_i};
      bounds_q  <= bounds_i;
      strides_q <= strides_i;
      const_q   <= iv_const_i;
      nbanks_q  <= log2_n_banks_i;
      sbank_q   <= start_bank_i;
    end
  end

  age_loop_ctr #(
    .N_DIMS  (N_DIMS),
    .NBIT_IV (NBIT_IV)
  ) u_ctr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (launch),
    .en_i         (issue),
    .bounds_i     (bounds_q),
    .iv_o         (iv),
    .inner_wrap_o (inner_wrap),
    .last_o       (ctr_last)
  );

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_DIMS; k++)
      sum_c = sum_c +
        NBIT_FLAT'(iv[k*NBIT_IV +: NBIT_IV]) *
        NBIT_FLAT'(strides_q[k*NBIT_STRIDE +: NBIT_STRIDE]);
  end

  // Block-cyclic split: block index picks the bank, the rest folds
  // into the intra-bank address around the in-block offset.
  always_comb begin
    sh_hi  = 5'(cfg_q.log2_block) + 5'(nbanks_q);
    bmask  = ~({LOG_N_BANKS{1'b1}} << nbanks_q);
    bidx_c = (LOG_N_BANKS'(s2_f_q >> cfg_q.log2_block) + sbank_q)
             & bmask;
    addr_c = NBIT_ADDR'(((s2_f_q >> sh_hi) << cfg_q.log2_block) |
             (s2_f_q & ~({NBIT_FLAT{1'b1}} << cfg_q.log2_block)));
    bank_d = '0;
    bank_d[bidx_c] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      s1_q       <= '0;
      s2_q       <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      acc_last_o <= 1'b0;
      lns_o      <= 1'b0;
    end else if (en) begin
      s1_q <= '{valid:    issue,
                last:     issue & ctr_last,
                acc_last: issue & cfg_q.acc_mode & inner_wrap,
                lns:      cfg_q.lns};
      s2_q <= s1_q;
      {valid_o, last_o, acc_last_o, lns_o} <= s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_sum_q   <= '0;
      s2_f_q     <= '0;
      addr_o     <= '0;
      bank_idx_o <= '0;
      bank_o     <= '0;
    end else if (en && !abort_i) begin
      s1_sum_q   <= sum_c;
      s2_f_q     <= s1_sum_q + const_q;
      addr_o     <= addr_c;
      bank_idx_o <= bidx_c;
      bank_o     <= bank_d;
    end
  end

  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;

endmodule

// File: tb/tb_age_nloop.sv
// Bench for age_nloop: mixed-radix stream model, in-order beat
// compare, directed literal streams and randomised configurations.
module tb_age_nloop;

  localparam int ND = 3, NIV = 8, NST = 16, NF = 20;
  localparam int NB = 8, LNB = 3, NA = 16;

  typedef logic [ND*NIV-1:0] bnd_t;
  typedef logic [ND*NST-1:0] str_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b1;
  bnd_t bounds_i = '0;
  str_t strides_i = '0;
  logic [NF-1:0] iv_const_i = '0;
  logic [1:0] l2nb_i = '0;
  logic [LNB-1:0] sbank_i = '0;
  logic [3:0] l2blk_i = '0;
  logic lns_i = 1'b0, acc_i = 1'b0;
  logic valid_o, lns_o, last_o, acc_last_o, busy_o, done_o;
  logic [NA-1:0] addr_o;
  logic [NB-1:0] bank_o;
  logic [LNB-1:0] bidx_o;

  always #5 clk = ~clk;

  age_nloop dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .bounds_i(bounds_i), .strides_i(strides_i),
    .iv_const_i(iv_const_i), .log2_n_banks_i(l2nb_i),
    .start_bank_i(sbank_i), .log2_block_i(l2blk_i),
    .lns_i(lns_i), .acc_mode_i(acc_i), .ready_i(ready_i),
    .valid_o(valid_o), .addr_o(addr_o), .bank_o(bank_o),
    .bank_idx_o(bidx_o), .lns_o(lns_o), .last_o(last_o),
    .acc_last_o(acc_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int addr; int bidx; bit last; bit acc; bit lns;
  } beat_t;
  beat_t exp_q[$];

  int mb[ND], ms[ND];
  int mk, mnb, mblk, msb;
  bit mlns, macc;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_acc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
  int done_cnt = 0, done_base = 0, start_edge = 0;
  int rdy_mode = 0, stall_left = 0;
  int cap_addr[64], cap_bidx[64];
  bit cap_last[64], cap_acc[64];
  bit prev_stall = 1'b0;
  longint prev_pl = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic longint pack(int a, int b, bit l, bit ac, bit ln);
    return longint'({16'(a), 3'(b), l, ac, ln});
  endfunction

  function automatic longint total();
    longint t = 1;
    for (int k = 0; k < ND; k++) t *= mb[k];
    return t;
  endfunction

  // Beat i of the stream is the mixed-radix decomposition of i.
  task automatic build();
    longint tot = total();
    for (longint i = 0; i < tot; i++) begin
      beat_t e;
      longint r, f, iv;
      r = i;
      f = mk;
      for (int k = 0; k < ND; k++) begin
        iv = r % mb[k];
        r  = r / mb[k];
        f += iv * ms[k];
      end
      f = f % (64'd1 << NF);
      e.bidx = int'(((f >> mblk) + msb) % (64'd1 << mnb));
      e.addr = int'((((f >> (mblk + mnb)) << mblk) |
                     (f % (64'd1 << mblk))) % 65536);
      e.last = (i == tot - 1);
      e.acc  = macc && (i % mb[0] == mb[0] - 1);
      e.lns  = mlns;
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) ready_i = 1'b1;
    else if (rdy_mode == 1) begin
      ready_i = !(valid_o && n_acc == 1 && stall_left > 0);
      if (!ready_i) stall_left--;
    end else ready_i = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_payload",
            pack(addr_o, bidx_o, last_o, acc_last_o, lns_o), prev_pl);
      end
      if (valid_o && first_cyc < 0) first_cyc = cyc;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_beat: got addr %0d expected none", addr_o);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat",
              pack(addr_o, bidx_o, last_o, acc_last_o, lns_o),
              pack(e.addr, e.bidx, e.last, e.acc, e.lns));
          chk("bank_onehot", bank_o, 64'd1 << e.bidx);
        end
        if (n_acc < 64) begin
          cap_addr[n_acc] = addr_o;
          cap_bidx[n_acc] = bidx_o;
          cap_last[n_acc] = last_o;
          cap_acc[n_acc]  = acc_last_o;
        end
        n_acc++;
        last_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = valid_o && !ready_i;
      prev_pl = pack(addr_o, bidx_o, last_o, acc_last_o, lns_o);
    end
  end

  task automatic start_stream();
    @(posedge clk); #1;
    for (int k = 0; k < ND; k++) begin
      bounds_i[k*NIV +: NIV]  = NIV'(mb[k]);
      strides_i[k*NST +: NST] = NST'(ms[k]);
    end
    iv_const_i = NF'(mk);
    l2nb_i = 2'(mnb);
    sbank_i = LNB'(msb);
    l2blk_i = 4'(mblk);
    lns_i = mlns;
    acc_i = macc;
    start_i = 1'b1;
    start_edge = cyc + 1;
    n_acc = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    done_base = done_cnt;
    build();
    @(posedge clk); #1;
    start_i = 1'b0;
    bounds_i = bnd_t'({$urandom, $urandom});
    strides_i = str_t'({$urandom, $urandom});
    iv_const_i = NF'($urandom);
    l2blk_i = 4'($urandom);
    sbank_i = LNB'($urandom);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (done_cnt == done_base && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == done_base) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done_o pulse");
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done_o, 0);
      chk("idle_after_done", busy_o, 0);
    end
  endtask

  task automatic cfg_2d();
    mb = '{2, 3, 1}; ms = '{1, 16, 0};
    mk = 4; mnb = 2; mblk = 0; msb = 0; mlns = 1'b1; macc = 1'b0;
  endtask

  task automatic chk_2d_beats();
    int la[6] = '{1, 1, 5, 5, 9, 9};
    chk("2d_count", n_acc, 6);
    for (int i = 0; i < 6; i++) begin
      chk("2d_addr", cap_addr[i], la[i]);
      chk("2d_bank", cap_bidx[i], i % 2);
      chk("2d_last", cap_last[i], i == 5);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_bank", bank_o, 0);
    chk("rst_outs",
        pack(addr_o, bidx_o, last_o, acc_last_o, lns_o), 0);
    chk("rst_busy_done", {busy_o, done_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    cfg_2d();
    start_stream();
    chk("model_pin_addr", exp_q[2].addr, 5);
    chk("model_pin_bank", exp_q[5].bidx, 1);
    @(negedge clk);
    chk("busy_run", busy_o, 1);
    wait_done(100);
    chk_2d_beats();
    chk("2d_latency", first_cyc, start_edge + 3);
    chk("2d_done_gap", done_cyc, last_cyc + 2);

    mb = '{8, 1, 1}; ms = '{1, 0, 0};
    mk = 0; mnb = 2; mblk = 1; msb = 3; mlns = 1'b0; macc = 1'b0;
    start_stream();
    wait_done(100);
    chk("bc_count", n_acc, 8);
    for (int i = 0; i < 8; i++) begin
      chk("bc_bank", cap_bidx[i], (3 + i / 2) % 4);
      chk("bc_addr", cap_addr[i], i % 2);
    end

    cfg_2d();
    rdy_mode = 1;
    stall_left = 3;
    start_stream();
    repeat (2) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done(100);
    rdy_mode = 0;
    chk("bp_stalled", stall_left, 0);
    chk_2d_beats();

    mb = '{4, 2, 1}; ms = '{1, 4, 0};
    mk = 0; mnb = 3; mblk = 0; msb = 0; mlns = 1'b0; macc = 1'b1;
    start_stream();
    wait_done(100);
    chk("acc_count", n_acc, 8);
    chk("acc_marks",
        {cap_acc[7], cap_acc[6], cap_acc[5], cap_acc[4],
         cap_acc[3], cap_acc[2], cap_acc[1], cap_acc[0]},
        8'b1000_1000);

    mb = '{0, 5, 1}; ms = '{1, 1, 1}; macc = 1'b0;
    start_stream();
    wait_done(20);
    chk("zero_beats", n_acc, 0);
    chk("zero_done_at", done_cyc, start_edge);

    mb = '{10, 10, 1}; ms = '{3, 40, 7};
    mk = 9; mnb = 1; mblk = 2; msb = 5; mlns = 1'b1;
    start_stream();
    k = 0;
    while (n_acc < 5 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("abort_reached", n_acc >= 5, 1);
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    exp_q.delete();
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt, done_base);
    chk("abort_idle", {busy_o, valid_o}, 0);
    cfg_2d();
    start_stream();
    wait_done(100);
    chk_2d_beats();
    chk("restart_latency", first_cyc, start_edge + 3);

    rdy_mode = 2;
    for (int t = 0; t < 25; t++) begin
      for (int d = 0; d < ND; d++) begin
        mb[d] = $urandom_range(1, 4);
        ms[d] = $urandom_range(0, 65535);
      end
      if ($urandom_range(0, 7) == 0) mb[$urandom_range(0, ND-1)] = 0;
      mk = $urandom_range(0, (1 << NF) - 1);
      mnb = $urandom_range(0, 3);
      mblk = $urandom_range(0, 15);
      msb = $urandom_range(0, 7);
      mlns = 1'($urandom_range(0, 1));
      macc = 1'($urandom_range(0, 1));
      start_stream();
      wait_done(2000);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_beats", n_acc, total());
    end
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
